// File: rtl/display_framebuffer_if.sv
// rtl/display_framebuffer_if.sv - loader/scan-driver bus into the double-buffered frame memory
interface display_framebuffer_if #(
  parameter int SEGMENTS = 1,
  parameter int ROWS     = 8,
  parameter int COLUMNS  = 32,
  parameter int BITWIDTH = 8
);
  localparam int W  = SEGMENTS * BITWIDTH * 3;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;

  // Loader side: column writes into the back bank plus the flip request
  logic [W-1:0]  wdata;
  logic          wen;
  logic [RW-1:0] wrow;
  logic [CW-1:0] wcol;
  logic          loaded;
  logic          ready;

  // Scan-driver side: registered reads from the front bank
  logic          ren;
  logic [RW-1:0] rrow;
  logic [CW-1:0] rcol;
  logic [W-1:0]  rdata;
  logic          frame_end;
  logic          front_bank;

  modport master (
    output wdata, wen, wrow, wcol, loaded, ren, rrow, rcol, frame_end,
    input  ready, rdata, front_bank
  );

  modport slave (
    input  wdata, wen, wrow, wcol, loaded, ren, rrow, rcol, frame_end,
    output ready, rdata, front_bank
  );
endinterface

// File: rtl/display_framebuffer.sv
// rtl/display_framebuffer.sv - double-buffered frame memory with frame-boundary bank flip
module display_framebuffer #(
  parameter int SEGMENTS = 1,
  parameter int ROWS     = 8,
  parameter int COLUMNS  = 32,
  parameter int BITWIDTH = 8
) (
  input logic                 i_clk,
  input logic                 i_rst,
  display_framebuffer_if.slave bus
);
  localparam int W     = SEGMENTS * BITWIDTH * 3;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW    = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam int AW    = 1 + RW + CW;
  localparam int RSPAN = 2 ** RW;
  localparam int CSPAN = 2 ** CW;

  // One bit per encodable row/column index, set where the index is real;
  // avoids range comparisons that collapse to constants for power-of-2 sizes.
  localparam logic [RSPAN-1:0] ROW_MASK = {RSPAN{1'b1}} >> (RSPAN - ROWS);
  localparam logic [CSPAN-1:0] COL_MASK = {CSPAN{1'b1}} >> (CSPAN - COLUMNS);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_front;
  logic           w_front_nxt;
  logic           r_ready;
  logic           w_ready_nxt;
  logic [W-1:0]   r_rdata;
  logic [W-1:0]   r_mem [2**AW];

  logic [AW-1:0]  w_waddr;
  logic [AW-1:0]  w_raddr;
  logic           w_wr_ok;
  logic           w_rd_ok;

  // Address = {bank, row, col}; writes always target the bank not on display
  assign w_waddr = {~r_front, bus.wrow, bus.wcol};
  assign w_raddr = {r_front, bus.rrow, bus.rcol};
  assign w_wr_ok = ROW_MASK[bus.wrow] & COL_MASK[bus.wcol];
  assign w_rd_ok = ROW_MASK[bus.rrow] & COL_MASK[bus.rcol];

  // Back-bank write port; contents survive reset by design
  always_ff @(posedge i_clk) begin
    if (bus.wen && w_wr_ok) begin
      r_mem[w_waddr] <= bus.wdata;
    end
  end

  // Front-bank registered read; holds its value while ren is low
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (bus.ren) begin
      r_rdata <= w_rd_ok ? r_mem[w_raddr] : '0;
    end
  end

  // Flip-handshake state, displayed bank and loader ready flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_front <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_front <= w_front_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  // IDLE waits for loaded; PENDING flips on the next frame_end, never in the same cycle as loaded
  always_comb begin
    w_state_nxt = r_state;
    w_front_nxt = r_front;
    w_ready_nxt = r_ready;
    case (r_state)
      IDLE: begin
        if (bus.loaded) begin
          w_state_nxt = PENDING;
          w_ready_nxt = 1'b0;
        end
      end
      PENDING: begin
        if (bus.frame_end) begin
          w_state_nxt = IDLE;
          w_front_nxt = ~r_front;
          w_ready_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.ready      = r_ready;
  assign bus.front_bank = r_front;
  assign bus.rdata      = r_rdata;
endmodule

// File: tb/tb_display_framebuffer.sv
// tb/tb_display_framebuffer.sv - self-checking bench for display_framebuffer
module tb_display_framebuffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  display_framebuffer_if bus ();

  display_framebuffer dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Behavioural model: two banks of words with written flags, a displayed-bank bit,
  // a pending-flip flag and the last word returned to the scan driver.
  logic [23:0] m_mem [2][8][32];
  bit          m_val [2][8][32];
  bit          m_front;
  bit          m_ready;
  bit          m_pend;
  logic [23:0] m_rdata;
  bit          m_known;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Model update on each edge, from the inputs held across that edge
  always @(posedge clk) begin
    bit f;
    if (rst) begin
      m_front = 1'b0;
      m_ready = 1'b1;
      m_pend  = 1'b0;
      m_rdata = '0;
      m_known = 1'b1;
    end else begin
      f = m_front;
      if (bus.wen) begin
        m_mem[!f][bus.wrow][bus.wcol] = bus.wdata;
        m_val[!f][bus.wrow][bus.wcol] = 1'b1;
      end
      if (bus.ren) begin
        m_known = m_val[f][bus.rrow][bus.rcol];
        m_rdata = m_mem[f][bus.rrow][bus.rcol];
      end
      if (m_pend) begin
        if (bus.frame_end) begin
          m_front = !f;
          m_pend  = 1'b0;
          m_ready = 1'b1;
        end
      end else if (bus.loaded) begin
        m_pend  = 1'b1;
        m_ready = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_ready", bus.ready, m_ready);
      chk("model_front", bus.front_bank, m_front);
      if (m_known) chk("model_rdata", bus.rdata, m_rdata);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    bus.wen       = 1'b0;
    bus.loaded    = 1'b0;
    bus.frame_end = 1'b0;
    bus.ren       = 1'b0;
  endtask

  task automatic wr(input int r, input int c, input logic [23:0] d);
    bus.wen   = 1'b1;
    bus.wrow  = 3'(r);
    bus.wcol  = 5'(c);
    bus.wdata = d;
    cyc();
  endtask

  task automatic rd(input int r, input int c);
    bus.ren  = 1'b1;
    bus.rrow = 3'(r);
    bus.rcol = 5'(c);
    cyc();
  endtask

  task automatic flip();
    bus.loaded = 1'b1;
    cyc();
    cyc();
    bus.frame_end = 1'b1;
    cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    bus.wen = 1'b0; bus.wdata = '0; bus.wrow = '0; bus.wcol = '0;
    bus.loaded = 1'b0; bus.frame_end = 1'b0;
    bus.ren = 1'b0; bus.rrow = '0; bus.rcol = '0;

    // Reset held two cycles, checked the cycle after release
    rst = 1'b1;
    cyc();
    cmp_en = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    @(negedge clk);
    chk("reset_ready", bus.ready, 1);
    chk("reset_front", bus.front_bank, 0);
    chk("reset_rdata", bus.rdata, 0);

    // Seed bank 0 at (3,5), then reset: front returns to 0, memory kept
    flip();
    wr(3, 5, 24'h5A5A5A);
    do_reset();
    @(negedge clk);
    chk("rst2_front", bus.front_bank, 0);
    chk("rst2_ready", bus.ready, 1);

    // Back-bank write is invisible to the scan side before a flip
    wr(3, 5, 24'hA1B2C3);
    rd(3, 5);
    @(negedge clk);
    chk("noflip_rdata", bus.rdata, 24'h5A5A5A);
    cyc();
    cyc();
    @(negedge clk);
    chk("rdata_hold", bus.rdata, 24'h5A5A5A);

    // Flip handshake: loaded at T, frame_end at T+10
    bus.loaded = 1'b1;
    cyc();
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk($sformatf("hs_ready_low_T%0d", i), bus.ready, 0);
      chk($sformatf("hs_front_T%0d", i), bus.front_bank, 0);
      if (i == 10) begin
        bus.frame_end = 1'b1;
        bus.ren = 1'b1; bus.rrow = 3'd3; bus.rcol = 5'd5;
        bus.wen = 1'b1; bus.wrow = 3'd3; bus.wcol = 5'd6; bus.wdata = 24'h0F0F0F;
      end
      cyc();
    end
    @(negedge clk);
    chk("hs_ready_T11", bus.ready, 1);
    chk("hs_front_T11", bus.front_bank, 1);
    chk("hs_flipcycle_read_old", bus.rdata, 24'h5A5A5A);
    rd(3, 5);
    @(negedge clk);
    chk("hs_rdata_T12", bus.rdata, 24'hA1B2C3);
    rd(3, 6);
    @(negedge clk);
    chk("flipcycle_write", bus.rdata, 24'h0F0F0F);

    // loaded and frame_end together in IDLE: no same-cycle flip
    bus.loaded = 1'b1;
    bus.frame_end = 1'b1;
    cyc();
    @(negedge clk);
    chk("sim_front_T1", bus.front_bank, 1);
    chk("sim_ready_T1", bus.ready, 0);
    cyc(); cyc(); cyc();
    @(negedge clk);
    chk("sim_front_T4", bus.front_bank, 1);
    bus.frame_end = 1'b1;
    cyc();
    @(negedge clk);
    chk("sim_front_T6", bus.front_bank, 0);
    chk("sim_ready_T6", bus.ready, 1);

    // Second loaded while pending: exactly one flip
    bus.loaded = 1'b1;
    cyc();
    cyc();
    bus.loaded = 1'b1;
    cyc();
    bus.frame_end = 1'b1;
    cyc();
    @(negedge clk);
    chk("dbl_front", bus.front_bank, 1);
    chk("dbl_ready", bus.ready, 1);
    bus.frame_end = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    chk("dbl_no_second_flip", bus.front_bank, 1);

    // Reset while pending discards the flip
    bus.loaded = 1'b1;
    cyc();
    @(negedge clk);
    chk("rstp_ready_low", bus.ready, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rstp_ready", bus.ready, 1);
    chk("rstp_front", bus.front_bank, 0);
    bus.frame_end = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    chk("rstp_no_flip", bus.front_bank, 0);
    chk("rstp_ready2", bus.ready, 1);

    // Address sweep through a flip, checked by the model
    for (int k = 0; k < 8; k++) begin
      wr(k, (k * 4 + 1) % 32, {8'(k), 8'(~k), 8'(k * 3 + 7)});
    end
    wr(7, 31, 24'hFEDCBA);
    wr(0, 0, 24'h123456);
    flip();
    for (int k = 0; k < 8; k++) begin
      rd(k, (k * 4 + 1) % 32);
    end
    rd(7, 31);
    @(negedge clk);
    chk("sweep_corner", bus.rdata, 24'hFEDCBA);
    rd(0, 0);
    @(negedge clk);
    chk("sweep_origin", bus.rdata, 24'h123456);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
